rotary_quad_decoder: RTL

//   Input-conditioning stage between the raw rotary encoder pins and the light-display logic.

---
 rtl/rotary_quad_decoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rotary_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rotary_quad_decoder
// Purpose  : Input conditioning for a rotary quadrature encoder. The raw
//            rotA/rotB pins are synchronised and debounced. One full
//            quadrature detent cycle is then decoded into a single-cycle
//            CW or CCW step pulse. The block also keeps a wrapping position
//            count and pulses err on illegal (two-bit) transitions.
// Ports    : clk       - system clock, rising edge
//            rst       - asynchronous reset, active-high
//            rotA      - raw encoder channel A (asynchronous to clk)
//            rotB      - raw encoder channel B (asynchronous to clk)
//            step_cw   - 1-cycle pulse, one complete CW detent decoded
//            step_ccw  - 1-cycle pulse, one complete CCW detent decoded
//            pos       - detent position, modulo 2**POS_W
//            err       - 1-cycle pulse, both filtered channels changed at once
// Revision : 1.0 - initial release
// ============================================================================
module rotary_quad_decoder #(
    parameter int DB_CYCLES = 1,   // stable cycles required before filt may change
    parameter int DB_W      = 4,   // debounce counter width, 2**DB_W > DB_CYCLES
    parameter int POS_W     = 8    // position counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rotA,
    input  logic             rotB,
    output logic             step_cw,
    output logic             step_ccw,
    output logic [POS_W-1:0] pos,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CW1  = 3'd1,
        CW2  = 3'd2,
        CW3  = 3'd3,
        CCW1 = 3'd4,
        CCW2 = 3'd5,
        CCW3 = 3'd6,
        WAIT = 3'd7
    } state_t;

    localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DB_CYCLES - 1);

    // Bit 1 carries channel A, bit 0 carries channel B throughout.
    logic [1:0]      w_raw;
    logic [1:0]      r_s1;
    logic [1:0]      r_s2;
    logic [1:0]      r_filt;
    logic [DB_W-1:0] r_cnt [2];

    // Filtered value seen on the previous cycle; used to spot two-bit jumps.
    logic [1:0]      r_ab_prev;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_step_cw;
    logic            w_step_ccw;
    logic            w_err;

    assign w_raw = {rotA, rotB};

    // ------------------------------------------------------------------
    // Two-flop synchroniser followed by a per-channel stability counter.
    // The counter only runs while the synchronised input disagrees with
    // the filtered value; any agreement restarts the stability window.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_filt <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_DB_LAST) begin
                    r_filt[i] <= r_s2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Quadrature FSM: state register, previous-value tracker and the
    // registered step/err/pos outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ab_prev <= 2'b00;
            step_cw   <= 1'b0;
            step_ccw  <= 1'b0;
            err       <= 1'b0;
            pos       <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ab_prev <= r_filt;
            step_cw   <= w_step_cw;
            step_ccw  <= w_step_ccw;
            err       <= w_err;
            if (w_step_cw) begin
                pos <= pos + POS_W'(1);
            end else if (w_step_ccw) begin
                pos <= pos - POS_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_cw   = 1'b0;
        w_step_ccw  = 1'b0;
        w_err       = 1'b0;

        if (r_state == WAIT) begin
            // Recovery only happens once both filtered channels are back at 00.
            if (r_filt == 2'b00) begin
                w_state_nxt = IDLE;
            end
        end else if (r_filt != r_ab_prev) begin
            if ((r_filt ^ r_ab_prev) == 2'b11) begin
                w_err       = 1'b1;
                w_state_nxt = (r_filt == 2'b00) ? IDLE : WAIT;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_filt == 2'b10) begin
                            w_state_nxt = CW1;
                        end else if (r_filt == 2'b01) begin
                            w_state_nxt = CCW1;
                        end
                    end
                    CW1: begin
                        if (r_filt == 2'b11) begin
                            w_state_nxt = CW2;
                        end else if (r_filt == 2'b00) begin
                            w_state_nxt = IDLE;
                        end
                    end
                    CW2: begin
                        if (r_filt == 2'b01) begin
                            w_state_nxt = CW3;
                        end else if (r_filt == 2'b10) begin
                            w_state_nxt = CW1;
                        end
                    end
                    CW3: begin
                        if (r_filt == 2'b00) begin
                            w_state_nxt = IDLE;
                            w_step_cw   = 1'b1;
                        end else if (r_filt == 2'b11) begin
                            w_state_nxt = CW2;
                        end
                    end
                    CCW1: begin
                        if (r_filt == 2'b11) begin
                            w_state_nxt = CCW2;
                        end else if (r_filt == 2'b00) begin
                            w_state_nxt = IDLE;
                        end
                    end
                    CCW2: begin
                        if (r_filt == 2'b10) begin
                            w_state_nxt = CCW3;
                        end else if (r_filt == 2'b01) begin
                            w_state_nxt = CCW1;
                        end
                    end
                    CCW3: begin
                        if (r_filt == 2'b00) begin
                            w_state_nxt = IDLE;
                            w_step_ccw  = 1'b1;
                        end else if (r_filt == 2'b11) begin
                            w_state_nxt = CCW2;
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
